// File: rtl/dm_responder.sv
// Handshaked multi-cycle data-memory responder.
// One request in flight; fixed access latency; registered response.
module dm_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [3:0]        req_be,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       wdata;
  } lreq_t;

  state_t state;
  state_t nstate;

  logic [3:0]  cnt;
  lreq_t       lat;
  logic [31:0] mem [DEPTH];

  logic              accept;
  logic              commit;
  logic              hshake;
  logic              misal;
  logic [ADDR_W-3:0] widx;

  assign accept = (state == IDLE) && req_valid;
  assign commit = (state == BUSY) && (cnt == 4'd0);
  assign hshake = (state == RESP) && resp_ready;
  assign misal  = lat.addr[1:0] != 2'b00;
  assign widx   = lat.addr[ADDR_W-1:2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (accept) nstate = BUSY;
      BUSY:    if (commit) nstate = RESP;
      RESP:    if (hshake) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= 4'd0;
      lat        <= '0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        lat.we    <= req_we;
        lat.addr  <= req_addr;
        lat.be    <= req_be;
        lat.wdata <= req_wdata;
        cnt       <= 4'(LATENCY - 1);
      end else if ((state == BUSY) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        resp_rdata <= (!lat.we && !misal) ? mem[widx] : 32'd0;
        resp_err   <= misal;
      end else if (hshake) begin
        resp_rdata <= 32'd0;
        resp_err   <= 1'b0;
      end
    end
  end

  // Array has no reset: contents survive rst and are undefined at power-up.
  always_ff @(posedge clk) begin
    if (commit && lat.we && !misal) begin
      for (int b = 0; b < 4; b++) begin
        if (lat.be[b]) mem[widx][8*b +: 8] <= lat.wdata[8*b +: 8];
      end
    end
  end

endmodule
